// File: rtl/rd_slot_scheduler.sv
// Read-slot scheduler: allocates, orders, retires and times out outstanding AXI reads for one ID.
// Optional statistics (max_outst_o, timeout_cnt_o) are built only when RD_SLOT_SCHED_STATS_EN is defined.
module rd_slot_scheduler #(
  parameter int NumSlots   = 4,
  parameter int CntWidth   = 8,
  parameter int LenWidth   = 8,
  parameter int BudgetBase = 16,
  parameter int BeatBudget = 2,
  localparam int IdxWidth  = $clog2(NumSlots)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ar_valid_i,
  input  logic                ar_ready_i,
  input  logic [LenWidth-1:0] ar_len_i,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  input  logic                clear_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [IdxWidth:0]   outstanding_o,
  output logic [IdxWidth-1:0] head_idx_o,
  output logic [IdxWidth-1:0] tail_idx_o,
  output logic                timeout_o,
  output logic [IdxWidth-1:0] timeout_slot_o,
  output logic                err_overflow_o,
  output logic                err_unexp_o,
  output logic [IdxWidth:0]   max_outst_o,
  output logic [7:0]          timeout_cnt_o
);

  localparam int FullW = LenWidth + 34;
  localparam logic [FullW-1:0] CntMax = {{(FullW-CntWidth){1'b0}}, {CntWidth{1'b1}}};
  localparam logic [IdxWidth:0] SlotCount = (IdxWidth+1)'(NumSlots);

  typedef enum logic [1:0] {IDLE, BUSY, TIMEOUT} state_e;

  state_e state_q, state_d;

  logic [NumSlots-1:0] busy_q;
  logic [CntWidth-1:0] cnt_q [NumSlots];
  logic [IdxWidth-1:0] next_q [NumSlots];
  logic [IdxWidth-1:0] head_q, tail_q, timeout_slot_q;
  logic [IdxWidth:0]   outstanding_q, outstanding_d;
  logic                err_overflow_q, err_unexp_q;

  logic                full, empty;
  logic                ar_hs, r_last_hs, alloc, rel;
  logic                free_found;
  logic [IdxWidth-1:0] free_idx;
  logic                expire_any;
  logic [IdxWidth-1:0] expire_idx;
  logic [FullW-1:0]    budget_full;
  logic [CntWidth-1:0] budget;

  assign ar_hs     = ar_valid_i & ar_ready_i;
  assign r_last_hs = r_valid_i & r_ready_i & r_last_i;
  assign alloc     = ar_hs & ~full & ~clear_i & free_found;
  assign rel       = r_last_hs & ~empty & (state_q != TIMEOUT) & ~clear_i;

  always_comb begin
    budget_full = FullW'(BudgetBase) + (FullW'(ar_len_i) + FullW'(1)) * FullW'(BeatBudget);
    budget      = (budget_full > CntMax) ? {CntWidth{1'b1}} : budget_full[CntWidth-1:0];
  end

  // Descending scans leave the lowest matching index in the result.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxWidth'(i);
      end
    end
  end

  always_comb begin
    expire_any = 1'b0;
    expire_idx = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (busy_q[i] && cnt_q[i] == '0 && !(rel && head_q == IdxWidth'(i))) begin
        expire_any = 1'b1;
        expire_idx = IdxWidth'(i);
      end
    end
  end

  always_comb begin
    if (clear_i) outstanding_d = '0;
    else         outstanding_d = outstanding_q + (IdxWidth+1)'(alloc) - (IdxWidth+1)'(rel);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clear_i)    state_d = IDLE;
        else if (alloc) state_d = BUSY;
      end
      BUSY: begin
        if (clear_i)                 state_d = IDLE;
        else if (expire_any)         state_d = TIMEOUT;
        else if (outstanding_d == 0) state_d = IDLE;
      end
      TIMEOUT: begin
        if (clear_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full      = (outstanding_q == SlotCount) || (state_q == TIMEOUT);
    empty     = (outstanding_q == '0);
    timeout_o = (state_q == TIMEOUT);
  end

  // Slot list: released head and freshly allocated slot are excluded from the countdown.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        cnt_q[i]  <= '0;
        next_q[i] <= '0;
      end
    end else if (clear_i) begin
      busy_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (state_q != TIMEOUT) begin
      for (int i = 0; i < NumSlots; i++) begin
        if (busy_q[i] && cnt_q[i] != '0 && !(rel && head_q == IdxWidth'(i))) begin
          cnt_q[i] <= cnt_q[i] - CntWidth'(1);
        end
      end
      if (rel) begin
        busy_q[head_q] <= 1'b0;
      end
      if (alloc) begin
        busy_q[free_idx] <= 1'b1;
        cnt_q[free_idx]  <= budget;
        tail_q           <= free_idx;
        if (!empty) next_q[tail_q] <= free_idx;
      end
      if (alloc && (empty || (rel && outstanding_q == (IdxWidth+1)'(1)))) begin
        head_q <= free_idx;
      end else if (rel) begin
        head_q <= next_q[head_q];
      end
      outstanding_q <= outstanding_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_slot_q <= '0;
    end else if (state_q == BUSY && state_d == TIMEOUT) begin
      timeout_slot_q <= expire_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_overflow_q <= 1'b0;
      err_unexp_q    <= 1'b0;
    end else begin
      if (ar_hs && full) err_overflow_q <= 1'b1;
      if (r_last_hs && empty && state_q != TIMEOUT) err_unexp_q <= 1'b1;
    end
  end

`ifdef RD_SLOT_SCHED_STATS_EN
  logic [IdxWidth:0] max_outst_q;
  logic [7:0]        timeout_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_outst_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (outstanding_d > max_outst_q) max_outst_q <= outstanding_d;
      if (state_q == BUSY && state_d == TIMEOUT && timeout_cnt_q != 8'hFF) begin
        timeout_cnt_q <= timeout_cnt_q + 8'd1;
      end
    end
  end

  assign max_outst_o   = max_outst_q;
  assign timeout_cnt_o = timeout_cnt_q;
`else
  assign max_outst_o   = '0;
  assign timeout_cnt_o = '0;
`endif

  assign full_o         = full;
  assign empty_o        = empty;
  assign outstanding_o  = outstanding_q;
  assign head_idx_o     = head_q;
  assign tail_idx_o     = tail_q;
  assign timeout_slot_o = timeout_slot_q;
  assign err_overflow_o = err_overflow_q;
  assign err_unexp_o    = err_unexp_q;

endmodule

// File: tb/tb_rd_slot_scheduler.sv
// Directed bench for rd_slot_scheduler: vector table for list handling plus hand-written timing sequences.
module tb_rd_slot_scheduler;

  logic       clk_i;
  logic       rst_ni;
  logic       ar_valid_i;
  logic       ar_ready_i;
  logic [7:0] ar_len_i;
  logic       r_valid_i;
  logic       r_ready_i;
  logic       r_last_i;
  logic       clear_i;
  logic       full_o;
  logic       empty_o;
  logic [2:0] outstanding_o;
  logic [1:0] head_idx_o;
  logic [1:0] tail_idx_o;
  logic       timeout_o;
  logic [1:0] timeout_slot_o;
  logic       err_overflow_o;
  logic       err_unexp_o;
  logic [2:0] max_outst_o;
  logic [7:0] timeout_cnt_o;

  int errors = 0;
  int checks = 0;

`ifdef RD_SLOT_SCHED_STATS_EN
  localparam int StatsOn = 1;
`else
  localparam int StatsOn = 0;
`endif

  rd_slot_scheduler dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .ar_valid_i     (ar_valid_i),
    .ar_ready_i     (ar_ready_i),
    .ar_len_i       (ar_len_i),
    .r_valid_i      (r_valid_i),
    .r_ready_i      (r_ready_i),
    .r_last_i       (r_last_i),
    .clear_i        (clear_i),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .outstanding_o  (outstanding_o),
    .head_idx_o     (head_idx_o),
    .tail_idx_o     (tail_idx_o),
    .timeout_o      (timeout_o),
    .timeout_slot_o (timeout_slot_o),
    .err_overflow_o (err_overflow_o),
    .err_unexp_o    (err_unexp_o),
    .max_outst_o    (max_outst_o),
    .timeout_cnt_o  (timeout_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       ar_v;
    logic       ar_r;
    logic [7:0] len;
    logic       r_v;
    logic       r_r;
    logic       r_last;
    logic       clr;
    logic       e_full;
    logic       e_empty;
    logic [2:0] e_outst;
    logic       chk_ht;
    logic [1:0] e_head;
    logic [1:0] e_tail;
    logic       e_ovf;
    logic       e_unexp;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t make_vec(
    input logic ar_v, input logic ar_r, input logic [7:0] len,
    input logic r_v, input logic r_r, input logic r_last, input logic clr,
    input logic e_full, input logic e_empty, input logic [2:0] e_outst,
    input logic chk_ht, input logic [1:0] e_head, input logic [1:0] e_tail,
    input logic e_ovf, input logic e_unexp);
    vec_t v;
    v.ar_v = ar_v;  v.ar_r = ar_r;  v.len = len;
    v.r_v = r_v;    v.r_r = r_r;    v.r_last = r_last;  v.clr = clr;
    v.e_full = e_full;  v.e_empty = e_empty;  v.e_outst = e_outst;
    v.chk_ht = chk_ht;  v.e_head = e_head;    v.e_tail = e_tail;
    v.e_ovf = e_ovf;    v.e_unexp = e_unexp;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic step(input logic ar_v, input logic ar_r, input logic [7:0] len,
                      input logic r_v, input logic r_r, input logic r_last, input logic clr);
    ar_valid_i = ar_v;
    ar_ready_i = ar_r;
    ar_len_i   = len;
    r_valid_i  = r_v;
    r_ready_i  = r_r;
    r_last_i   = r_last;
    clear_i    = clr;
    @(posedge clk_i);
    #1;
    ar_valid_i = 1'b0;
    ar_ready_i = 1'b0;
    ar_len_i   = 8'd0;
    r_valid_i  = 1'b0;
    r_ready_i  = 1'b0;
    r_last_i   = 1'b0;
    clear_i    = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    step(v.ar_v, v.ar_r, v.len, v.r_v, v.r_r, v.r_last, v.clr);
  endtask

  task automatic send_ar(input logic [7:0] len);
    step(1'b1, 1'b1, len, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_rlast();
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    ar_valid_i = 1'b0;  ar_ready_i = 1'b0;  ar_len_i = 8'd0;
    r_valid_i  = 1'b0;  r_ready_i  = 1'b0;  r_last_i = 1'b0;
    clear_i    = 1'b0;  rst_ni     = 1'b0;

    //                ar_v  ar_r  len    r_v   r_r   rlast clr    full  empty outst ht    head  tail  ovf   unexp
    vecs[0]  = make_vec(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    vecs[1]  = make_vec(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    vecs[2]  = make_vec(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    vecs[3]  = make_vec(1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0);
    vecs[4]  = make_vec(1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0);
    vecs[5]  = make_vec(1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0);
    vecs[6]  = make_vec(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 2'd0, 2'd3, 1'b1, 1'b0);
    vecs[7]  = make_vec(1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 2'd1, 2'd3, 1'b1, 1'b0);
    vecs[8]  = make_vec(1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0);
    vecs[9]  = make_vec(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0);
    vecs[10] = make_vec(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0);
    vecs[11] = make_vec(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0);
    vecs[12] = make_vec(1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0);
    vecs[13] = make_vec(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    vecs[14] = make_vec(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    vecs[15] = make_vec(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1);

    do_reset();
    checkOutput("rst_empty", empty_o, 1);
    checkOutput("rst_full", full_o, 0);
    checkOutput("rst_outst", outstanding_o, 0);
    checkOutput("rst_timeout", timeout_o, 0);
    checkOutput("rst_ovf", err_overflow_o, 0);
    checkOutput("rst_unexp", err_unexp_o, 0);
    checkOutput("rst_max_outst", max_outst_o, 0);
    checkOutput("rst_timeout_cnt", timeout_cnt_o, 0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_full", i), full_o, vecs[i].e_full);
      checkOutput($sformatf("vec%0d_empty", i), empty_o, vecs[i].e_empty);
      checkOutput($sformatf("vec%0d_outst", i), outstanding_o, vecs[i].e_outst);
      checkOutput($sformatf("vec%0d_ovf", i), err_overflow_o, vecs[i].e_ovf);
      checkOutput($sformatf("vec%0d_unexp", i), err_unexp_o, vecs[i].e_unexp);
      checkOutput($sformatf("vec%0d_timeout", i), timeout_o, 0);
      if (vecs[i].chk_ht) begin
        checkOutput($sformatf("vec%0d_head", i), head_idx_o, vecs[i].e_head);
        checkOutput($sformatf("vec%0d_tail", i), tail_idx_o, vecs[i].e_tail);
      end
    end
    checkOutput("table_max_outst", max_outst_o, StatsOn * 4);

    // Asynchronous reset with three reads in flight and sticky errors set.
    send_ar(8'd0);
    send_ar(8'd0);
    send_ar(8'd0);
    checkOutput("mid_outst_before", outstanding_o, 3);
    rst_ni = 1'b0;
    #1;
    checkOutput("mid_rst_empty", empty_o, 1);
    checkOutput("mid_rst_outst", outstanding_o, 0);
    checkOutput("mid_rst_full", full_o, 0);
    checkOutput("mid_rst_ovf", err_overflow_o, 0);
    checkOutput("mid_rst_unexp", err_unexp_o, 0);
    checkOutput("mid_rst_max_outst", max_outst_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    send_rlast();
    checkOutput("mid_unexp_after", err_unexp_o, 1);
    checkOutput("mid_empty_after", empty_o, 1);

    // Single read retired well before its budget of 24 runs out.
    do_reset();
    send_ar(8'd3);
    idle(8);
    send_rlast();
    checkOutput("single_empty", empty_o, 1);
    checkOutput("single_timeout", timeout_o, 0);
    idle(30);
    checkOutput("single_timeout_late", timeout_o, 0);

    // len=3 gives 24 cycles of budget; expiry is seen on the following edge.
    do_reset();
    send_ar(8'd3);
    idle(24);
    checkOutput("b24_not_yet", timeout_o, 0);
    idle(1);
    checkOutput("b24_timeout", timeout_o, 1);

    // len=255 would be 528 cycles; saturates to 255.
    do_reset();
    send_ar(8'd255);
    idle(255);
    checkOutput("sat_not_yet", timeout_o, 0);
    idle(1);
    checkOutput("sat_timeout", timeout_o, 1);

    // Head released on the edge where its counter is 0 is a release, not a timeout.
    do_reset();
    send_ar(8'd0);
    idle(18);
    send_rlast();
    checkOutput("zero_rel_timeout", timeout_o, 0);
    checkOutput("zero_rel_empty", empty_o, 1);
    checkOutput("zero_rel_unexp", err_unexp_o, 0);

    // Timeout of slot 0, then TIMEOUT behaviour and clear.
    do_reset();
    send_ar(8'd0);
    idle(18);
    checkOutput("to_not_yet", timeout_o, 0);
    checkOutput("to_full_before", full_o, 0);
    idle(1);
    checkOutput("to_timeout", timeout_o, 1);
    checkOutput("to_slot", timeout_slot_o, 0);
    checkOutput("to_full", full_o, 1);
    send_ar(8'd0);
    checkOutput("to_ar_ignored", outstanding_o, 1);
    send_rlast();
    checkOutput("to_r_ignored", outstanding_o, 1);
    checkOutput("to_r_no_unexp", err_unexp_o, 0);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("to_clear_timeout", timeout_o, 0);
    checkOutput("to_clear_empty", empty_o, 1);
    checkOutput("to_clear_full", full_o, 0);

    // Younger slot 1 (budget 18) expires before older slot 0 (budget 24).
    do_reset();
    send_ar(8'd3);
    send_ar(8'd0);
    idle(18);
    checkOutput("to1_not_yet", timeout_o, 0);
    idle(1);
    checkOutput("to1_timeout", timeout_o, 1);
    checkOutput("to1_slot", timeout_slot_o, 1);
    checkOutput("to1_cnt", timeout_cnt_o, StatsOn);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("to1_slot_held", timeout_slot_o, 1);
    checkOutput("to1_cleared", timeout_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
